id_ex_stage: RTL and testbench

- Pipeline register between the decode stage (main control decoder, register file read, immediate generator) and the execute stage.
- Captures the decoder's control bundle (Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite) together with the operands.
- Detects load-use hazards and inserts bubbles.
- Honours branch flush and a valid/ready handshake to EX.

---
 rtl/id_ex_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: 1-cycle latency; holds under ex_ready=0, inserts load-use bubbles, flush kills.
// Optional ID_EX_PERF_COUNTERS_EN adds bubble_count / flush_count outputs.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALUOP_WIDTH    = 2,
  parameter int FUNCT_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic                      id_branch,
  input  logic                      id_mem_read,
  input  logic                      id_mem_to_reg,
  input  logic                      id_mem_write,
  input  logic                      id_alu_src,
  input  logic                      id_reg_write,
  input  logic [ALUOP_WIDTH-1:0]    id_alu_op,
  input  logic [FUNCT_WIDTH-1:0]    id_funct,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      ex_ready,
  output logic                      ex_valid,
  output logic                      ex_branch,
  output logic                      ex_mem_read,
  output logic                      ex_mem_to_reg,
  output logic                      ex_mem_write,
  output logic                      ex_alu_src,
  output logic                      ex_reg_write,
  output logic [ALUOP_WIDTH-1:0]    ex_alu_op,
  output logic [FUNCT_WIDTH-1:0]    ex_funct,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [DATA_WIDTH-1:0]     ex_rs1_data,
  output logic [DATA_WIDTH-1:0]     ex_rs2_data,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
`ifdef ID_EX_PERF_COUNTERS_EN
  output logic                      hazard_stall,
  output logic [31:0]               bubble_count,
  output logic [31:0]               flush_count
`else
  output logic                      hazard_stall
`endif
);

  logic bubble;

  // Conservative: both source indices are compared whatever the opcode.
  assign hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                        ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign id_ready     = flush | ((~ex_valid | ex_ready) & ~hazard_stall);
  assign bubble       = ~flush & hazard_stall & ex_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_op     <= '0;
      ex_funct      <= '0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
    end else if (flush || bubble || (!(ex_valid && !ex_ready) && !id_valid)) begin
      // Empty slot: controls zeroed so EX needs no valid gating; payload holds.
      ex_valid      <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
    end else if (id_valid && id_ready) begin
      ex_valid      <= 1'b1;
      ex_branch     <= id_branch;
      ex_mem_read   <= id_mem_read;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_mem_write  <= id_mem_write;
      ex_alu_src    <= id_alu_src;
      ex_reg_write  <= id_reg_write;
      ex_alu_op     <= id_alu_op;
      ex_funct      <= id_funct;
      ex_pc         <= id_pc;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
    end
  end

`ifdef ID_EX_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (bubble) bubble_count <= bubble_count + 32'd1;
      if (flush && (ex_valid || id_valid)) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage: reference model predicts EX state per cycle, monitor compares.
module tb_id_ex_stage;

  typedef struct packed {
    logic        vld, br, mr, m2r, mw, as, rw;
    logic [1:0]  op;
    logic [3:0]  fn;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] bub, fl;
  } st_t;

  logic clk = 1'b0;
  logic rst_n, flush, ex_ready;
  st_t  id;  // vld field used as id_valid; counters unused

  logic        id_ready, hazard_stall;
  logic        ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0]  ex_alu_op;
  logic [3:0]  ex_funct;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] bubble_count, flush_count;

  int vectors = 0;
  int errors  = 0;
  st_t exp_q[$];
  st_t m = '0;
  logic m_rdy = 1'b1;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id.vld), .id_ready(id_ready),
    .id_branch(id.br), .id_mem_read(id.mr), .id_mem_to_reg(id.m2r), .id_mem_write(id.mw),
    .id_alu_src(id.as), .id_reg_write(id.rw), .id_alu_op(id.op), .id_funct(id.fn),
    .id_pc(id.pc), .id_rs1_data(id.r1d), .id_rs2_data(id.r2d), .id_imm(id.imm),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
`ifdef ID_EX_PERF_COUNTERS_EN
    .hazard_stall(hazard_stall), .bubble_count(bubble_count), .flush_count(flush_count)
`else
    .hazard_stall(hazard_stall)
`endif
  );

`ifndef ID_EX_PERF_COUNTERS_EN
  assign bubble_count = '0;
  assign flush_count  = '0;
`endif

  // Reference model: evaluated mid-cycle, predicts the EX register contents after the next edge.
  always @(negedge clk) begin
    logic haz, rdy;
    st_t  n;
    haz = id.vld && m.vld && m.mr && (m.rd != 0) && (m.rd == id.rs1 || m.rd == id.rs2);
    rdy = flush || ((!m.vld || ex_ready) && !haz);
    if (rst_n) begin
      vectors++;
      if (hazard_stall !== haz) begin
        errors++;
        $display("FAIL hazard_stall t=%0t got=%b want=%b", $time, hazard_stall, haz);
      end
      vectors++;
      if (id_ready !== rdy) begin
        errors++;
        $display("FAIL id_ready t=%0t got=%b want=%b", $time, id_ready, rdy);
      end
    end
    m_rdy = rdy;
    n = m;
    if (!rst_n) begin
      n = '0;
    end else if (flush) begin
      {n.vld, n.br, n.mr, n.m2r, n.mw, n.as, n.rw} = '0;
      if (m.vld || id.vld) n.fl = m.fl + 1;
    end else if (haz && ex_ready) begin
      {n.vld, n.br, n.mr, n.m2r, n.mw, n.as, n.rw} = '0;
      n.bub = m.bub + 1;
    end else if (m.vld && !ex_ready) begin
      n = m;
    end else if (id.vld) begin
      n = id;
      n.vld = 1'b1;
      n.bub = m.bub;
      n.fl  = m.fl;
    end else begin
      {n.vld, n.br, n.mr, n.m2r, n.mw, n.as, n.rw} = '0;
    end
`ifndef ID_EX_PERF_COUNTERS_EN
    n.bub = '0;
    n.fl  = '0;
`endif
    m = n;
    exp_q.push_back(n);
  end

  // Monitor: after each edge, compare the registered EX state with the predicted one.
  initial begin
    forever begin
      st_t a, e;
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
              ex_reg_write, ex_alu_op, ex_funct, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
              ex_rs1, ex_rs2, ex_rd, bubble_count, flush_count};
        vectors++;
        if (a !== e) begin
          errors++;
          $display("FAIL ex_state t=%0t got=%h want=%h", $time, a, e);
        end
      end
    end
  end

  task automatic rand_id();
    id     = st_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    id.vld = 1'b1;
    id.rs1 = 5'($urandom_range(0, 7));
    id.rs2 = 5'($urandom_range(0, 7));
    id.rd  = 5'($urandom_range(0, 7));
    id.bub = '0;
    id.fl  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    rand_id();
    id.op = 2'b10; id.rw = 1'b1; id.mr = 1'b0;
    step(); step();
    // Back-to-back R-type after reset release
    rst_n = 1'b1; id.rd = 5'd5; step();
    rand_id(); id.op = 2'b10; id.rw = 1'b1; id.mr = 1'b0; id.rd = 5'd6; step();
    // Load-use with rd=x7, consumer reads rs2=7
    rand_id(); id.mr = 1'b1; id.rd = 5'd7; step();
    rand_id(); id.mr = 1'b0; id.rs1 = 5'd1; id.rs2 = 5'd7; step(); step();
    // Load to x0 never stalls
    rand_id(); id.mr = 1'b1; id.rd = 5'd0; step();
    rand_id(); id.mr = 1'b0; id.rs1 = 5'd0; id.rs2 = 5'd0; step();
    // Backpressure hold of pc=0x100, then 0x104 loads
    rand_id(); id.mr = 1'b0; id.pc = 32'h100; step();
    rand_id(); id.mr = 1'b0; id.pc = 32'h104; ex_ready = 1'b0; step(); step(); step();
    ex_ready = 1'b1; step();
    // Flush and hazard in the same cycle
    rand_id(); id.mr = 1'b1; id.rd = 5'd3; step();
    rand_id(); id.rs1 = 5'd3; flush = 1'b1; step();
    flush = 1'b0; rand_id(); step();
    // Reset during a backpressure hold
    ex_ready = 1'b0; rand_id(); step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; ex_ready = 1'b1; rand_id(); step();
    // Random traffic; an unaccepted instruction stays upstream
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 9) < 7);
      if (m_rdy || !id.vld) begin
        rand_id();
        id.vld = ($urandom_range(0, 4) != 0);
      end
      step();
    end
    rst_n = 1'b1; flush = 1'b0; id.vld = 1'b0; ex_ready = 1'b1;
    step(); step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
